// File: rtl/drlp_layer_seq_pkg.sv
// Shared DRLP sequencer definitions: state encoding, layer geometry and
// the config register address map used by both sequencer and config block.
package drlp_layer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_CLR,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    localparam int DRLP_CFG_WIDTH       = 32;
    localparam int DRLP_CFG_ADDR_WIDTH  = 3;
    localparam int DRLP_CFG_WORDS       = 6;
    localparam int DRLP_START_ADDR      = 6;
    localparam int DRLP_DESC_ADDR_WIDTH = 10;
    localparam int DRLP_LAYER_WIDTH     = 8;

    // cfg register map: descriptor words land at 0..5, start at 6
    localparam int DRLP_REG_DESC0 = 0;
    localparam int DRLP_REG_DESC5 = DRLP_CFG_WORDS - 1;
    localparam int DRLP_REG_START = DRLP_START_ADDR;

endpackage

// File: rtl/drlp_layer_seq_if.sv
// Host, descriptor-memory and config-bus signals of the layer sequencer.
// master is the sequencer side, slave is the environment side.
interface drlp_layer_seq_if
    import drlp_layer_seq_pkg::*;
#(
    parameter int CFG_WIDTH       = DRLP_CFG_WIDTH,
    parameter int CFG_ADDR_WIDTH  = DRLP_CFG_ADDR_WIDTH,
    parameter int DESC_ADDR_WIDTH = DRLP_DESC_ADDR_WIDTH,
    parameter int LAYER_WIDTH     = DRLP_LAYER_WIDTH
);

    logic                       i_go;
    logic                       i_abort;
    logic [DESC_ADDR_WIDTH-1:0] i_desc_base;
    logic [LAYER_WIDTH-1:0]     i_layer_num;
    logic                       o_desc_rd_en;
    logic [DESC_ADDR_WIDTH-1:0] o_desc_rd_addr;
    logic [CFG_WIDTH-1:0]       i_desc_rd_data;
    logic [CFG_WIDTH-1:0]       o_cfg;
    logic [CFG_ADDR_WIDTH-1:0]  o_cfg_addr;
    logic                       o_cfg_wr_en;
    logic                       i_finish;
    logic                       o_busy;
    logic [LAYER_WIDTH-1:0]     o_layer_idx;
    logic                       o_done;

    modport master (
        input  i_go,
        input  i_abort,
        input  i_desc_base,
        input  i_layer_num,
        output o_desc_rd_en,
        output o_desc_rd_addr,
        input  i_desc_rd_data,
        output o_cfg,
        output o_cfg_addr,
        output o_cfg_wr_en,
        input  i_finish,
        output o_busy,
        output o_layer_idx,
        output o_done
    );

    modport slave (
        output i_go,
        output i_abort,
        output i_desc_base,
        output i_layer_num,
        input  o_desc_rd_en,
        input  o_desc_rd_addr,
        output i_desc_rd_data,
        input  o_cfg,
        input  o_cfg_addr,
        input  o_cfg_wr_en,
        output i_finish,
        input  o_busy,
        input  o_layer_idx,
        input  o_done
    );

endinterface

// File: rtl/drlp_layer_seq.sv
// Multi-layer command sequencer: streams per-layer descriptors onto the
// cfg bus, pulses start, waits for finish, and walks to the next layer.
module drlp_layer_seq
    import drlp_layer_seq_pkg::*;
#(
    parameter int CFG_WIDTH       = DRLP_CFG_WIDTH,
    parameter int CFG_ADDR_WIDTH  = DRLP_CFG_ADDR_WIDTH,
    parameter int CFG_WORDS       = DRLP_CFG_WORDS,
    parameter int START_ADDR      = DRLP_START_ADDR,
    parameter int DESC_ADDR_WIDTH = DRLP_DESC_ADDR_WIDTH,
    parameter int LAYER_WIDTH     = DRLP_LAYER_WIDTH
) (
    input logic              i_clk,
    input logic              i_rst,
    drlp_layer_seq_if.master bus
);

    localparam int CNT_W = $clog2(CFG_WORDS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(CFG_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CFG_ADDR_WIDTH-1:0] START_REG =
        CFG_ADDR_WIDTH'(START_ADDR);
    localparam logic [CFG_WIDTH-1:0] START_SET =
        CFG_WIDTH'(1);
    localparam logic [DESC_ADDR_WIDTH-1:0] PTR_ONE =
        DESC_ADDR_WIDTH'(1);
    localparam logic [LAYER_WIDTH-1:0] IDX_ONE =
        LAYER_WIDTH'(1);

    seq_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DESC_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [LAYER_WIDTH-1:0]     idx_q, idx_d;
    logic [LAYER_WIDTH-1:0]     num_q, num_d;
    logic                       finish_q;
    logic                       abort_q, abort_d;

    logic finish_rise;
    logic last_layer;

    assign finish_rise = bus.i_finish & ~finish_q;
    assign last_layer  = (idx_q == num_q - IDX_ONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            idx_q    <= '0;
            num_q    <= '0;
            finish_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            finish_q <= bus.i_finish;
            abort_q  <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        num_d   = num_q;
        abort_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_go && !bus.i_abort) begin
                    ptr_d = bus.i_desc_base;
                    num_d = bus.i_layer_num;
                    idx_d = '0;
                    cnt_d = '0;
                    if (bus.i_layer_num == '0)
                        state_d = ST_DONE;
                    else
                        state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.i_abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q < CNT_LAST) begin
                    ptr_d = ptr_q + PTR_ONE;
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = ST_START;
                end
            end
            // an abort here still passes through CLR so start drops
            ST_START: begin
                state_d = ST_CLR;
                abort_d = bus.i_abort;
            end
            ST_CLR: begin
                if (abort_q || bus.i_abort)
                    state_d = ST_IDLE;
                else
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_abort) begin
                    state_d = ST_IDLE;
                end else if (finish_rise) begin
                    if (last_layer) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_desc_rd_en   = 1'b0;
        bus.o_desc_rd_addr = '0;
        bus.o_cfg_wr_en    = 1'b0;
        bus.o_cfg_addr     = '0;
        bus.o_cfg          = '0;
        bus.o_done         = 1'b0;
        bus.o_busy         = (state_q != ST_IDLE);
        bus.o_layer_idx    = idx_q;
        unique case (state_q)
            // read of word n overlaps the cfg write of word n-1
            ST_LOAD: begin
                bus.o_desc_rd_en   = (cnt_q < CNT_LAST);
                bus.o_desc_rd_addr = ptr_q;
                bus.o_cfg_wr_en    = (cnt_q != '0);
                bus.o_cfg_addr     =
                    CFG_ADDR_WIDTH'(cnt_q - CNT_ONE);
                bus.o_cfg          = bus.i_desc_rd_data;
            end
            ST_START: begin
                bus.o_cfg_wr_en = 1'b1;
                bus.o_cfg_addr  = START_REG;
                bus.o_cfg       = START_SET;
            end
            ST_CLR: begin
                bus.o_cfg_wr_en = 1'b1;
                bus.o_cfg_addr  = START_REG;
                bus.o_cfg       = '0;
            end
            ST_DONE: bus.o_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/drlp_layer_seq.md
# drlp_layer_seq

Multi-layer command sequencer for the DRLP accelerator. It walks a table of per-layer configuration descriptors in a synchronous descriptor memory and programs the configuration register bus word by word. It then pulses the start register, waits for the accelerator's finish indication, and advances to the next layer. It sits between the host/control port and the accelerator's `i_cfg*` bus, so a whole network runs from a single host command.

## Interface
Parameters:
- `CFG_WIDTH`, 32: config bus data width.
- `CFG_ADDR_WIDTH`, 3: config register address width.
- `CFG_WORDS`, 6: descriptor words per layer, written to cfg addresses 0..CFG_WORDS-1.
- `START_ADDR`, 6: cfg address of the start register.
- `DESC_ADDR_WIDTH`, 10: descriptor memory address width.
- `LAYER_WIDTH`, 8: layer count/index width.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous active-high reset.
- `i_go` in 1: single-cycle run request, honoured only in IDLE.
- `i_abort` in 1: abort the current run.
- `i_desc_base` in DESC_ADDR_WIDTH: descriptor address of layer 0, word 0.
- `i_layer_num` in LAYER_WIDTH: number of layers to run.
- `o_desc_rd_en` out 1: descriptor memory read enable.
- `o_desc_rd_addr` out DESC_ADDR_WIDTH: descriptor memory read address.
- `i_desc_rd_data` in CFG_WIDTH: read data, valid one cycle after the read.
- `o_cfg` out CFG_WIDTH: config write data.
- `o_cfg_addr` out CFG_ADDR_WIDTH: config write address.
- `o_cfg_wr_en` out 1: config write strobe.
- `i_finish` in 1: accelerator finish, a level signal.
- `o_busy` out 1: high in every state except IDLE.
- `o_layer_idx` out LAYER_WIDTH: index of the current layer.
- `o_done` out 1: one-cycle pulse when all layers have completed.

## Operation
- States are IDLE, LOAD, START, CLR, WAIT, DONE.
- Registers: `cnt` (0..CFG_WORDS), `ptr` (descriptor address), `layer_idx`, `num_q`, `finish_q`.
- **IDLE:**
  - On `i_go`, latch `ptr=i_desc_base` and `num_q=i_layer_num`, and clear `layer_idx`.
  - If `i_layer_num==0`, go to DONE; otherwise go to LOAD with `cnt=0`.
- **LOAD** (read and write are pipelined):
  - `o_desc_rd_en=(cnt<CFG_WORDS)`, `o_desc_rd_addr=ptr`; `ptr` increments on each read.
  - `o_cfg_wr_en=(cnt>0)`, `o_cfg_addr=cnt-1`, `o_cfg=i_desc_rd_data`.
  - When `cnt==CFG_WORDS`, go to START; otherwise `cnt++`.
- **START:** write `o_cfg_addr=START_ADDR`, `o_cfg=1`, then go to CLR.
- **CLR:** write `START_ADDR` with 0, then go to WAIT.
- **WAIT:**
  - Leave on the finish rising edge, `i_finish & ~finish_q`.
  - If `layer_idx==num_q-1`, go to DONE.
  - Otherwise `layer_idx++`, `cnt=0`, and go to LOAD. `ptr` is already at the next layer's first word, so descriptors are contiguous.
- **DONE:** `o_done=1` for one cycle, then go to IDLE.
- **Abort:**
  - `i_abort` in any non-IDLE state goes to IDLE next cycle, with no `o_done`.
  - If the state is START, the next cycle still writes start=0 before IDLE, so start is never left set.
  - `i_abort` has priority over `i_go` and over the finish edge.
- `i_go` while busy is ignored. `ptr` wraps modulo 2^DESC_ADDR_WIDTH.

## Timing
- Outputs are Moore outputs decoded from state/`cnt` registers. `finish_q` is updated every cycle.
- Reset values:
  - `o_busy`, `o_done`, `o_cfg_wr_en`, `o_desc_rd_en` are 0.
  - `o_cfg`, `o_cfg_addr`, `o_desc_rd_addr`, `o_layer_idx` are 0.
  - State is IDLE and `finish_q` is 0.
- `i_go` sampled at edge 0:
  - Cycle 1: read word 0.
  - Cycles 2..7: write cfg 0..5.
  - Cycle 8: START. Cycle 9: CLR. Cycle 10 onward: WAIT.
- A finish edge seen in WAIT in cycle n gives LOAD, or DONE, in cycle n+1.
- Each layer costs CFG_WORDS+4 cycles plus compute time.
- If `i_finish` is already high on entry to WAIT (a stale level), it is not an edge; a new 0→1 transition is required.
- `i_rst` mid-run returns to IDLE next cycle with all outputs at reset values.

## Structure
- Shared `drlp` package/header holds the state encoding, `CFG_WORDS`, `START_ADDR`, and the cfg address map (shared with the config block).
- No sub-module; the finish edge detector is a single flop inline.

## Test plan
- Single layer: base=0x10, num=1, memory words 0xA0..0xA5 → `o_cfg_wr_en` in cycles 2..7 with addr 0..5 and data 0xA0..0xA5; addr 6 data 1 in cycle 8, data 0 in cycle 9; finish edge → `o_done` pulse, `o_busy` falls.
- Three layers: num=3 → reads 0x10..0x21 contiguous; `o_layer_idx` steps 0,1,2; exactly 3 start pulses; one `o_done`.
- Stale finish: `i_finish` held high from the previous run → no advance until it drops and rises again.
- Zero layers: num=0 → `o_done` in cycle 1, no cfg writes, no reads.
- Abort during START → the next cycle writes start=0, then IDLE; no `o_done`. A new `i_go` restarts from layer 0.
- Reset asserted in WAIT → IDLE next cycle, all outputs 0; `i_go` while busy is ignored, checked by asserting it mid-LOAD.
